// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic matrix-multiply tile.
// Saturating add is used only when SYSTOLIC_TILE_SAT_EN is defined.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    FLUSH,
    DRAIN
  } state_t;

  function automatic logic signed [63:0] sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int                 w
  );
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi)      sat_add = hi;
    else if (s < lo) sat_add = lo;
    else             sat_add = s;
  endfunction

endpackage

// File: rtl/systolic_tile_if.sv
// Operand, result and job-control bundle of the systolic tile.
// slave is the tile side, master the producer/consumer side.
interface systolic_tile_if #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int K_MAX  = 255,
  parameter int K_W    = $clog2(K_MAX + 1)
);
  logic                   start;
  logic [K_W-1:0]         k_len;
  logic                   in_valid;
  logic                   in_ready;
  logic [ROWS*DATA_W-1:0] in_a;
  logic [COLS*DATA_W-1:0] in_b;
  logic                   res_valid;
  logic                   res_ready;
  logic [COLS*ACC_W-1:0]  res_data;
  logic                   res_last;
  logic                   busy;

  modport slave (
    input  start, k_len, in_valid, in_a, in_b, res_ready,
    output in_ready, res_valid, res_data, res_last, busy
  );

  modport master (
    output start, k_len, in_valid, in_a, in_b, res_ready,
    input  in_ready, res_valid, res_data, res_last, busy
  );
endinterface

// File: rtl/systolic_pe.sv
// One output-stationary MAC cell with registered a/b pass-through.
// Build option SYSTOLIC_TILE_SAT_EN selects saturating accumulation.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] b_in,
  output logic signed [DATA_W-1:0] a_out,
  output logic signed [DATA_W-1:0] b_out,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    term;
  logic signed [ACC_W-1:0]    nxt;

  assign prod = a_in * b_in;
  assign term = ACC_W'(prod);

`ifdef SYSTOLIC_TILE_SAT_EN
  assign nxt = ACC_W'(sat_add(64'(acc), 64'(term), ACC_W));
`else
  assign nxt = acc + term;
`endif

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      acc   <= '0;
      a_out <= '0;
      b_out <= '0;
    end else if (en) begin
      acc   <= nxt;
      a_out <= a_in;
      b_out <= b_in;
    end
  end

endmodule

// File: rtl/systolic_tile.sv
// Output-stationary ROWS x COLS systolic tile with job FSM, input skew
// and valid/ready streams. Option macro: SYSTOLIC_TILE_SAT_EN.
module systolic_tile
  import systolic_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int K_MAX  = 255,
  localparam int K_W   = $clog2(K_MAX + 1)
) (
  input logic            clk,
  input logic            reset,
  systolic_tile_if.slave bus
);

  localparam int FL = ROWS + COLS - 2;
  localparam int CW = (K_W > $clog2(ROWS + COLS)) ?
                      K_W : $clog2(ROWS + COLS);

  if (ACC_W < 2 * DATA_W) begin : g_bad_acc
    $error("ACC_W must be at least 2*DATA_W");
  end

  state_t         state;
  state_t         state_d;
  logic [CW-1:0]  cnt;
  logic [K_W-1:0] klen_q;
  logic           feed;
  logic           fire;
  logic           en;
  logic           clr;
  logic           adv;
  logic           last_beat;
  logic           last_row;

  assign feed      = state == FEED;
  assign fire      = feed && bus.in_valid;
  assign en        = fire || state == FLUSH;
  assign clr       = state == IDLE && bus.start;
  assign last_beat = (cnt + CW'(1)) == CW'(klen_q);
  assign last_row  = cnt == CW'(ROWS - 1);
  assign adv       = fire || state == FLUSH ||
                     (state == DRAIN && bus.res_ready);

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:
        if (bus.start)
          state_d = (bus.k_len != '0) ? FEED : DRAIN;
      FEED:
        if (fire && last_beat)
          state_d = (FL == 0) ? DRAIN : FLUSH;
      FLUSH:
        if (cnt == CW'(FL - 1)) state_d = DRAIN;
      DRAIN:
        if (bus.res_ready && last_row) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      klen_q <= '0;
    end else begin
      state <= state_d;
      if (state_d != state) cnt <= '0;
      else if (adv)         cnt <= cnt + CW'(1);
      if (clr) klen_q <= bus.k_len;
    end
  end

  logic signed [DATA_W-1:0] a_h [ROWS][COLS+1];
  logic signed [DATA_W-1:0] b_v [ROWS+1][COLS];
  logic signed [ACC_W-1:0]  acc [ROWS][COLS];

  // Row r and column c are delayed r and c enabled steps respectively.
  for (genvar r = 0; r < ROWS; r++) begin : g_ask
    logic signed [DATA_W-1:0] src;
    assign src = feed ? bus.in_a[r*DATA_W +: DATA_W] : '0;
    if (r == 0) begin : g_d0
      assign a_h[r][0] = src;
    end else begin : g_sr
      logic signed [DATA_W-1:0] sr [r];
      always_ff @(posedge clk) begin
        if (!reset || clr) begin
          sr <= '{default: '0};
        end else if (en) begin
          sr[0] <= src;
          for (int i = 1; i < r; i++) sr[i] <= sr[i-1];
        end
      end
      assign a_h[r][0] = sr[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_bsk
    logic signed [DATA_W-1:0] src;
    assign src = feed ? bus.in_b[c*DATA_W +: DATA_W] : '0;
    if (c == 0) begin : g_d0
      assign b_v[0][c] = src;
    end else begin : g_sr
      logic signed [DATA_W-1:0] sr [c];
      always_ff @(posedge clk) begin
        if (!reset || clr) begin
          sr <= '{default: '0};
        end else if (en) begin
          sr[0] <= src;
          for (int i = 1; i < c; i++) sr[i] <= sr[i-1];
        end
      end
      assign b_v[0][c] = sr[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      systolic_pe #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
      ) u_pe (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .clr  (clr),
        .a_in (a_h[r][c]),
        .b_in (b_v[r][c]),
        .a_out(a_h[r][c+1]),
        .b_out(b_v[r+1][c]),
        .acc  (acc[r][c])
      );
    end
  end

  logic [COLS*ACC_W-1:0] res_row;

  always_comb begin
    res_row = '0;
    for (int r = 0; r < ROWS; r++)
      if (state == DRAIN && cnt == CW'(r))
        for (int c = 0; c < COLS; c++)
          res_row[c*ACC_W +: ACC_W] = acc[r][c];
  end

  assign bus.in_ready  = feed;
  assign bus.busy      = state != IDLE;
  assign bus.res_valid = state == DRAIN;
  assign bus.res_last  = state == DRAIN && last_row;
  assign bus.res_data  = res_row;

endmodule

// File: tb/tb_systolic_tile.sv
// Scoreboard bench for systolic_tile: random jobs against a plain
// sum-of-products model, with backpressure on both streams.
module tb_systolic_tile;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int K_MAX  = 255;
  localparam int K_W    = $clog2(K_MAX + 1);

  typedef logic [COLS*ACC_W-1:0] vec_t;
  typedef struct {
    vec_t data;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  systolic_tile_if #(
    .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W),
    .ACC_W(ACC_W), .K_MAX(K_MAX), .K_W(K_W)
  ) bus ();

  systolic_tile #(
    .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W),
    .ACC_W(ACC_W), .K_MAX(K_MAX)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   ma [ROWS][K_MAX];
  int   mb [K_MAX][COLS];
  exp_t exp_q [$];
  int   rdy_pct = 100;
  bit   lat_chk = 0;
  int   last_fire_cyc = 0;
  bit   ir_seen = 0;

  always @(posedge clk) cyc++;

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_row(string name, vec_t act, vec_t req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: C[r][c] = sum_k A[r][k]*B[k][c], wrapped or clamped per term.
  function automatic void push_expected(int k);
    exp_t e;
    longint acc;
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (ACC_W - 1)) - 1;
    lo = -hi - 1;
    for (int r = 0; r < ROWS; r++) begin
      e.data = '0;
      for (int c = 0; c < COLS; c++) begin
        acc = 0;
        for (int kk = 0; kk < k; kk++) begin
          acc = acc + longint'(ma[r][kk]) * longint'(mb[kk][c]);
`ifdef SYSTOLIC_TILE_SAT_EN
          if (acc > hi) acc = hi;
          if (acc < lo) acc = lo;
`endif
        end
        e.data[c*ACC_W +: ACC_W] = acc[ACC_W-1:0];
      end
      e.last = (r == ROWS - 1);
      exp_q.push_back(e);
    end
  endfunction

  vec_t hold_d;
  logic hold_l;
  bit   stalled = 0;
  bit   prev_v = 0;

  always @(negedge clk) begin
    if (bus.in_ready) ir_seen = 1;
    if (!reset) begin
      stalled = 0;
      prev_v  = 0;
    end else begin
      if (stalled) begin
        chk("hold_valid", int'(bus.res_valid), 1);
        chk_row("hold_data", bus.res_data, hold_d);
        chk("hold_last", int'(bus.res_last), int'(hold_l));
      end
      if (!bus.res_valid) chk_row("idle_data", bus.res_data, '0);
      if (bus.res_valid && !prev_v && lat_chk) begin
        chk("latency", cyc - last_fire_cyc, ROWS + COLS - 1);
        lat_chk = 0;
      end
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%h required=none",
                   bus.res_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk_row("res_data", bus.res_data, e.data);
          chk("res_last", int'(bus.res_last), int'(e.last));
        end
      end
      stalled = bus.res_valid && !bus.res_ready;
      hold_d  = bus.res_data;
      hold_l  = bus.res_last;
      prev_v  = bus.res_valid;
    end
  end

  initial begin
    bus.res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.res_ready = ($urandom_range(99) < rdy_pct);
    end
  end

  task automatic wait_done(bit poke);
    int  g;
    bit  poked;
    g = 0;
    poked = 0;
    while ((exp_q.size() != 0 || bus.busy) && g < 5000) begin
      @(negedge clk);
      if (poke && bus.res_valid && !poked) begin
        bus.start = 1'b1;
        bus.k_len = K_W'(2);
        poked = 1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
      end
      g++;
    end
    chk("drain_timeout", int'(g < 5000), 1);
    chk("queue_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("busy_done", int'(bus.busy), 0);
    if (poke) begin
      repeat (3) @(negedge clk);
      chk("start_ignored", int'(bus.busy), 0);
    end
  endtask

  task automatic run_job(int k, int vpct, bit poke);
    int i;
    int guard;
    bit fire;
    push_expected(k);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.k_len = K_W'(k);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    i = 0;
    guard = 0;
    while (i < k && guard < 5000) begin
      bus.in_valid = ($urandom_range(99) < vpct);
      for (int r = 0; r < ROWS; r++)
        bus.in_a[r*DATA_W +: DATA_W] = bus.in_valid ?
          DATA_W'(ma[r][i]) : DATA_W'($urandom);
      for (int c = 0; c < COLS; c++)
        bus.in_b[c*DATA_W +: DATA_W] = bus.in_valid ?
          DATA_W'(mb[i][c]) : DATA_W'($urandom);
      if (poke && i == 100) begin
        bus.start = 1'b1;
        bus.k_len = K_W'(3);
      end
      @(negedge clk);
      fire = bus.in_valid && bus.in_ready;
      if (fire && i == k - 1) begin
        last_fire_cyc = cyc;
        lat_chk = 1;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (fire) i++;
      guard++;
    end
    bus.in_valid = 1'b0;
    chk("feed_timeout", int'(guard < 5000), 1);
    wait_done(poke);
  endtask

  task automatic fill_rand(int k);
    for (int kk = 0; kk < k; kk++) begin
      for (int r = 0; r < ROWS; r++)
        ma[r][kk] = int'($urandom_range(255)) - 128;
      for (int c = 0; c < COLS; c++)
        mb[kk][c] = int'($urandom_range(255)) - 128;
    end
  endtask

  task automatic fill_const(int k, int v);
    for (int kk = 0; kk < k; kk++) begin
      for (int r = 0; r < ROWS; r++) ma[r][kk] = v;
      for (int c = 0; c < COLS; c++) mb[kk][c] = v;
    end
  endtask

  task automatic chk_quiet(string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_in_ready"}, int'(bus.in_ready), 0);
    chk({tag, "_res_valid"}, int'(bus.res_valid), 0);
    chk({tag, "_res_last"}, int'(bus.res_last), 0);
    chk_row({tag, "_res_data"}, bus.res_data, '0);
  endtask

  initial begin
    int k;
    bus.start    = 1'b0;
    bus.k_len    = '0;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Abort a k_len=4 job after two beats.
    fill_rand(4);
    bus.start = 1'b1;
    bus.k_len = K_W'(4);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a = '1;
    bus.in_b = '1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("midreset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    fill_rand(4);
    run_job(4, 100, 0);

    // Identity A with B rows 1..16.
    for (int kk = 0; kk < 4; kk++) begin
      for (int r = 0; r < ROWS; r++) ma[r][kk] = (r == kk) ? 1 : 0;
      for (int c = 0; c < COLS; c++) mb[kk][c] = 4 * kk + c + 1;
    end
    run_job(4, 100, 0);

    // Same random data, without and with stalls on both sides.
    for (int j = 0; j < 3; j++) begin
      k = $urandom_range(16, 1);
      fill_rand(k);
      rdy_pct = 100;
      run_job(k, 100, 0);
      rdy_pct = 50;
      run_job(k, 50, 0);
    end
    rdy_pct = 100;

    ir_seen = 0;
    run_job(0, 100, 0);
    chk("k0_no_in_ready", int'(ir_seen), 0);

    fill_const(4, -128);
    run_job(4, 100, 0);

    fill_const(K_MAX, -1);
    rdy_pct = 60;
    run_job(K_MAX, 100, 1);
    rdy_pct = 100;

    fill_rand(1);
    run_job(1, 70, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_tile.md
Name: systolic_tile

Overview:
- Parametrised output-stationary systolic matrix-multiply tile; successor to the fixed 4x4 hpe array.
- Computes C[ROWS][COLS] = A[ROWS][k_len] x B[k_len][COLS].
- Adds three things the fixed array lacks: a job controller, built-in input skew, and valid/ready streaming on both the operand and result sides.
- Sits between the operand fetch unit and the result writer.

Parameters:
- ROWS, 4, PE rows (>=1)
- COLS, 4, PE columns (>=1)
- DATA_W, 8, signed operand width
- ACC_W, 16, signed accumulator width; elaboration error if ACC_W < 2*DATA_W
- K_MAX, 255, maximum inner dimension; K_W = $clog2(K_MAX+1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  job start pulse; honoured only in IDLE
- k_len  in  K_W  inner dimension; sampled with start
- in_valid  in  1  operand beat valid
- in_ready  out  1  operand beat accepted
- in_a  in  ROWS*DATA_W  column k of A; row r at [r*DATA_W +: DATA_W]
- in_b  in  COLS*DATA_W  row k of B; column c at [c*DATA_W +: DATA_W]
- res_valid  out  1  result beat valid
- res_ready  in  1  result beat consumed
- res_data  out  COLS*ACC_W  one row of C; column c at [c*ACC_W +: ACC_W]
- res_last  out  1  marks the final result row
- busy  out  1  job in progress

Behaviour:
- Reset (reset=0 at a clk edge), from any state including mid-job:
  - state goes to IDLE
  - accumulators, skew registers, PE pass-through registers and counters clear
  - outputs in_ready, res_valid, res_last, busy are 0; res_data is 0
- States: IDLE, FEED, FLUSH, DRAIN.
- IDLE:
  - busy=0, in_ready=0.
  - On start: clear all accumulators, latch k_len.
  - Next state is FEED if k_len!=0, otherwise DRAIN (all-zero result).
- FEED:
  - busy=1, in_ready=1.
  - Each fire (in_valid & in_ready) produces one enabled array step and increments beat count.
  - A cycle without fire freezes the whole array: skew registers, PEs and accumulators.
  - After beat k_len-1 fires: next state is FLUSH, or DRAIN if ROWS+COLS-2 == 0.
- FLUSH:
  - busy=1, in_ready=0.
  - Runs exactly ROWS+COLS-2 enabled steps with zero operands injected, then goes to DRAIN.
- Timing model:
  - In-row skew: row r delayed r steps; column c delayed c steps (shift registers gated by array enable).
  - At enabled step t, PE(r,c) accumulates a[r][k]*b[k][c] with k = t-r-c, when 0<=k<k_len.
  - Each PE registers its a/b pass-through to its right/lower neighbour.
- DRAIN:
  - busy=1, res_valid=1.
  - res_data shows accumulator row i, starting at i=0.
  - i advances on res_valid & res_ready.
  - res_last=1 while i==ROWS-1.
  - After the final handshake: IDLE, res_valid=0.
  - res_data and res_last hold stable while res_valid & !res_ready.
  - Array is disabled throughout.
- res_data is 0 whenever res_valid=0.
- start outside IDLE is ignored. in_valid outside FEED is ignored.
- Arithmetic: two's complement. The 2*DATA_W product is sign-extended to ACC_W; accumulation wraps modulo 2^ACC_W.
- Latency:
  - start to in_ready: 1 cycle.
  - Last operand fire to res_valid: ROWS+COLS-1 cycles.

Optional Feature:
- Macro: SYSTOLIC_TILE_SAT_EN.
- Defined: each accumulate saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; once saturated, the value is retained through later terms in the same direction.
- Undefined: wrap-around accumulation as above.
- Ports and timing are identical in both builds.

Decomposition:
- Package systolic_pkg holds:
  - the state enum typedef (IDLE/FEED/FLUSH/DRAIN)
  - a signed saturating-add function, used only under the macro
- Sub-module systolic_pe holds:
  - one MAC with en and clr
  - registered a_out/b_out
  - acc output
- systolic_tile instantiates ROWS*COLS systolic_pe in a generate grid, plus the skew shift registers and the FSM.

Test Plan:
- Reset mid-FEED: drive reset=0 for 3 cycles after 2 beats of k_len=4 -> busy, in_ready, res_valid all 0. A fresh job then gives correct results with no residue.
- Identity (4x4, k_len=4): A=I, B rows {1..4},{5..8},{9..12},{13..16} -> 4 result beats equal to the B rows; res_last only on beat 4; res_valid 7 cycles after last fire.
- Backpressure: in_valid random at 50%, res_ready toggling -> results bit-identical to the no-stall run; res_data stable while stalled.
- k_len=0: start -> no in_ready pulse; 4 result beats, all zero.
- Signed extremes (DATA_W=8, ACC_W=16): all operands -128, k_len=4, sum 65536 -> each element 0 without the macro, 32767 with SYSTOLIC_TILE_SAT_EN.
- Control: start asserted during FEED/DRAIN ignored; k_len=255 with all-ones operands -> every element 255; busy deasserts after last res handshake.
